mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the Asic's single external memory port (mem_req/mem_resp to ExtMem) between NREQ internal requesters: the weight-stream fetcher, the vector-stream fetcher and the result writer. Round-robin arbitration with grant lock, plus an in-order ID queue that steers each ExtMem response back to the requester that issued it. Sits between the matrix/vector datapath and the Asic's mem_* ports. No address or data transformation.

## Interface
- NREQ, 3, number of requesters (index 0 = weights, 1 = vector, 2 = results)
- DEPTH, 4, max outstanding requests (ID queue depth, power of 2)
- ADDR_W, 40, address width
- DATA_W, 64, data width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid_i  in  NREQ  per-requester request valid
- req_ready_o  out  NREQ  per-requester request accepted this cycle
- req_addr_i  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_cmd_i  in  NREQ*5  packed commands (0 = read, 1 = write)
- req_typ_i  in  NREQ*3  packed access types (3 = 64-bit)
- req_data_i  in  NREQ*DATA_W  packed store data
- resp_valid_o  out  NREQ  one-hot response strobe to the owning requester
- resp_data_o  out  DATA_W  response data, broadcast to all requesters
- mem_req_valid_o / mem_req_ready_i  out/in  1  ExtMem request handshake
- mem_req_addr_o, mem_req_cmd_o, mem_req_typ_o, mem_req_data_o  out  ADDR_W/5/3/DATA_W  granted requester's fields
- mem_resp_valid_i  in  1  ExtMem response strobe
- mem_resp_data_i  in  DATA_W  ExtMem response data
- outstanding_o  out  clog2(DEPTH)+1  requests issued and not yet answered
- err_o  out  1  sticky: response arrived with empty ID queue

## Operation
- ExtMem returns exactly one response per accepted request, reads and writes alike, in issue order. The arbiter does not interpret cmd/typ.
- Grant selection: when not locked and not full, grant the first requester with req_valid_i set, searching from rr_ptr upward, mod NREQ. The index order is rr_ptr, rr_ptr+1, ….
- mem_req_valid_o = valid of the granted requester. mem_req_* fields are muxed combinationally from the granted requester.
- Lock: if mem_req_valid_o=1 and mem_req_ready_i=0, the grant is held next cycle regardless of other requesters. Requesters must hold valid and fields stable until ready.
- Fire = mem_req_valid_o & mem_req_ready_i. On fire:
  - req_ready_o[grant]=1 (other bits 0).
  - push grant into the ID queue.
  - rr_ptr ← grant+1 mod NREQ.
  - lock clears.
- Full (outstanding_o == DEPTH): mem_req_valid_o=0 and req_ready_o=0 for all requesters. Lock state is irrelevant because a locked grant cannot exist at full.
- Response: on mem_resp_valid_i with queue non-empty, pop the head ID h. That cycle, drive resp_valid_o = one-hot(h) and resp_data_o = mem_resp_data_i.
- Response with empty queue: resp_valid_o=0, err_o←1 (sticky until reset).
- Fire and response in the same cycle: push and pop both happen, outstanding_o is unchanged, and the queue pointers advance correctly.
- No requester valid: mem_req_valid_o=0, and rr_ptr and lock hold.

## Timing
- Request path: zero latency, combinational valid/ready pass-through on the granted requester.
- Response path: zero latency, combinational pass-through. resp_valid_o depends only on registered queue head and mem_resp_valid_i.
- Reset values: rr_ptr=0, lock=0, queue empty, outstanding_o=0, err_o=0. Combinational outputs are all 0 with no valid inputs.
- Reset asserted mid-operation clears all state immediately. IDs of in-flight requests are discarded; their later responses set err_o.
- Queue wrap-around uses modulo-DEPTH read/write pointers, with separate count.
- Sustained throughput: one request per cycle while not full. With DEPTH outstanding, the next request is accepted in the cycle after the response that drains a slot. A full queue never issues in the same cycle as the pop.

## Test plan
- Single requester: req 0 reads addr 0x0 and ExtMem responds 0x11 → one mem fire, resp_valid_o=3'b001, resp_data_o=0x11, outstanding_o returns to 0.
- All three valid continuously with ready=1 → grant sequence 0,1,2,0,1,2; responses 0xA,0xB,0xC are strobed to requesters 0,1,2 in order.
- Lock: req 1 valid and ready low for 3 cycles while req 0 raises valid → mem_req_addr_o stays req 1's address until fire, then req 0 is granted.
- Full: issue 4 reads with no responses → 5th request stalled (ready 0, mem_req_valid_o 0). Supply one response → outstanding_o 4→3, 5th request fires next cycle.
- Simultaneous fire and response at outstanding_o=2 → outstanding_o stays 2, response routed to the oldest ID.
- Assert reset (low) with 2 outstanding, release, then deliver a response → resp_valid_o stays 0, err_o=1, outstanding_o=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one ExtMem request port among NREQ requesters with round-robin grant and
// grant lock; an in-order ID queue steers each ExtMem response back to its issuer.
module mem_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64,
  localparam int OUT_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NREQ*5-1:0]        req_cmd_i,
  input  logic [NREQ*3-1:0]        req_typ_i,
  input  logic [NREQ*DATA_W-1:0]   req_data_i,
  output logic [NREQ-1:0]          resp_valid_o,
  output logic [DATA_W-1:0]        resp_data_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [ADDR_W-1:0]        mem_req_addr_o,
  output logic [4:0]               mem_req_cmd_o,
  output logic [2:0]               mem_req_typ_o,
  output logic [DATA_W-1:0]        mem_req_data_o,
  input  logic                     mem_resp_valid_i,
  input  logic [DATA_W-1:0]        mem_resp_data_i,
  output logic [OUT_W-1:0]         outstanding_o,
  output logic                     err_o
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             lock;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] id_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OUT_W-1:0] count;
  logic             err;
  logic             full;
  logic             fire;
  logic             pop;
  int               idx;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    grant = rr_ptr;
    idx   = 0;
    if (lock) begin
      grant = lock_idx;
    end else begin
      // Walk offsets from the far end so the nearest valid requester to rr_ptr wins.
      for (int i = NREQ - 1; i >= 0; i--) begin
        idx = int'(rr_ptr) + i;
        if (idx >= NREQ) idx = idx - NREQ;
        if (req_valid_i[idx]) grant = IDX_W'(idx);
      end
    end
  end

  assign full            = (count == OUT_W'(DEPTH));
  assign mem_req_valid_o = !full && req_valid_i[grant];
  assign fire            = mem_req_valid_o && mem_req_ready_i;
  assign req_ready_o     = fire ? (NREQ'(1) << grant) : '0;

  assign mem_req_addr_o  = mem_req_valid_o ? req_addr_i[grant*ADDR_W +: ADDR_W] : '0;
  assign mem_req_cmd_o   = mem_req_valid_o ? req_cmd_i[grant*5 +: 5]            : '0;
  assign mem_req_typ_o   = mem_req_valid_o ? req_typ_i[grant*3 +: 3]            : '0;
  assign mem_req_data_o  = mem_req_valid_o ? req_data_i[grant*DATA_W +: DATA_W] : '0;

  // A response with nothing outstanding is dropped and flagged instead of routed.
  assign pop           = mem_resp_valid_i && (count != '0);
  assign resp_valid_o  = pop ? (NREQ'(1) << id_q[rd_ptr]) : '0;
  assign resp_data_o   = mem_resp_data_i;
  assign outstanding_o = count;
  assign err_o         = err;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      if (fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant == IDX_W'(NREQ - 1)) ? '0 : grant + 1'b1;
        lock   <= 1'b0;
      end else if (mem_req_valid_o) begin
        lock     <= 1'b1;
        lock_idx <= grant;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (mem_resp_valid_i && count == '0) err <= 1'b1;
      count <= count + OUT_W'(fire) - OUT_W'(pop);
    end
  end

  // NOTE: the ID storage has no reset; entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (fire) id_q[wr_ptr] <= grant;
  end

endmodule
